serial_settings_rx_marine_radar: RTL and testbench



---
 rtl/serial_settings_pkg.sv | 20 ++
 rtl/sync_edge.sv | 33 +++
 rtl/serial_settings_rx_marine_radar.sv | 164 ++++++++++++++++
 tb/tb_serial_settings_rx_marine_radar.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_settings_pkg.sv
// Shared frame constants and FSM state type for the settings-bus serial receiver.
package serial_settings_pkg;

  localparam int FRAME_BITS = 40;
  localparam int HDR_BITS   = 8;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;

  // Bit counter is wide enough to hold any position inside a full frame.
  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the
// synchronized value. All flops reset to 0, so a line already low at reset
// release never produces a falling-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              q_prev;

  // Shift the asynchronous input through the chain; remember the last output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
      q_prev  <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      q_prev  <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/serial_settings_rx_marine_radar.sv
// Settings-bus initiator: deserializes 3-wire FX2 frames (sen_n/sclk/sdata)
// into master_clk-domain register writes, and optionally answers read frames.
// Optional feature: define SERIAL_READBACK_EN to enable read-frame readback.
// Handshake: serial_strobe is a one-cycle valid with no ready; serial_addr and
// serial_data are updated in the strobe cycle and held until the next write.
module serial_settings_rx_marine_radar
  import serial_settings_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              sen_n,
  input  logic              sclk,
  input  logic              sdata_in,
  output logic              sdata_out,
  output logic              sdata_oe,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic              serial_strobe,
  output logic [ADDR_W-1:0] readback_addr,
  input  logic [DATA_W-1:0] readback_data,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_DATA     = CNT_W'(DATA_W);

  logic sen_start, sen_end, sclk_rise, sclk_fall, sdata_s;
  logic sen_n_unused_q, sclk_unused_q, sdata_unused_rise, sdata_unused_fall;

  // sen_n falling edge starts a frame, rising edge ends it.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sen (
    .clk(master_clk), .rst_n(reset_n), .d(sen_n),
    .q(sen_n_unused_q), .rise(sen_end), .fall(sen_start)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(master_clk), .rst_n(reset_n), .d(sclk),
    .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Data shares the clock's synchronizer depth so each bit lines up with its edge.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(master_clk), .rst_n(reset_n), .d(sdata_in),
    .q(sdata_s), .rise(sdata_unused_rise), .fall(sdata_unused_fall)
  );

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [HDR_BITS-1:0] hdr_sr;
  logic [DATA_W-1:0]  data_sr;
  logic               strobe_nxt, err_nxt;
  logic               hdr_is_read;

  // Bit 7 of the header as it will look once the current sclk bit is shifted in.
  assign hdr_is_read = hdr_sr[HDR_BITS-2];

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt  = state;
    strobe_nxt = 1'b0;
    err_nxt    = 1'b0;
    if (sen_end) begin
      state_nxt  = IDLE;
      strobe_nxt = (state == WDATA) && (bit_cnt == CNT_DATA);
      err_nxt    = (state == HDR) || (state == ERR) ||
                   (((state == WDATA) || (state == RDATA)) && (bit_cnt != CNT_DATA));
    end else begin
      case (state)
        IDLE: if (sen_start) state_nxt = HDR;
        HDR: begin
          if (sclk_rise && (bit_cnt == CNT_HDR_LAST)) begin
            if (hdr_is_read) begin
`ifdef SERIAL_READBACK_EN
              state_nxt = RDATA;
`else
              state_nxt = ERR;
`endif
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        WDATA, RDATA: if (sclk_rise && (bit_cnt == CNT_DATA)) state_nxt = ERR;
        default: state_nxt = state;
      endcase
    end
  end

  // State, bit counter, shift registers and settings-bus outputs.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      hdr_sr        <= '0;
      data_sr       <= '0;
      serial_addr   <= '0;
      serial_data   <= '0;
      serial_strobe <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      serial_strobe <= strobe_nxt;
      frame_err     <= err_nxt;
      if (strobe_nxt) begin
        serial_addr <= hdr_sr[ADDR_W-1:0];
        serial_data <= data_sr;
      end
      if ((state == IDLE) && sen_start) begin
        bit_cnt <= '0;
      end else if (sclk_rise && !sen_end) begin
        case (state)
          HDR: begin
            hdr_sr  <= {hdr_sr[HDR_BITS-2:0], sdata_s};
            bit_cnt <= (bit_cnt == CNT_HDR_LAST) ? '0 : bit_cnt + 1'b1;
          end
          WDATA: begin
            data_sr <= {data_sr[DATA_W-2:0], sdata_s};
            bit_cnt <= bit_cnt + 1'b1;
          end
          RDATA:   bit_cnt <= bit_cnt + 1'b1;
          default: bit_cnt <= bit_cnt;
        endcase
      end
    end
  end

`ifdef SERIAL_READBACK_EN
  logic [DATA_W-1:0] tx_sr;
  logic              load_pend;

  // Latch the read address at header end, capture the word one cycle later,
  // then advance on sclk falls once the first data bit has been clocked.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      readback_addr <= '0;
      load_pend     <= 1'b0;
      tx_sr         <= '0;
    end else begin
      load_pend <= 1'b0;
      if ((state == HDR) && (state_nxt == RDATA)) begin
        readback_addr <= {hdr_sr[ADDR_W-2:0], sdata_s};
        load_pend     <= 1'b1;
      end
      if (load_pend) begin
        tx_sr <= readback_data;
      end else if ((state == RDATA) && sclk_fall && (bit_cnt != '0)) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign sdata_out = tx_sr[DATA_W-1];
  assign sdata_oe  = (state == RDATA);
`else
  logic readback_unused;
  assign readback_unused = ^readback_data;
  assign readback_addr   = '0;
  assign sdata_out       = 1'b0;
  assign sdata_oe        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_settings_rx_marine_radar.sv
// Bench for serial_settings_rx_marine_radar: directed frames plus random
// frames, with a scoreboard queue of expected strobe / frame_err events.
module tb_serial_settings_rx_marine_radar;

  localparam int SYNC = 2;
  localparam int HALF = SYNC + 2;
`ifdef SERIAL_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        master_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic        sen_n      = 1'b1;
  logic        sclk       = 1'b0;
  logic        sdata_in   = 1'b0;
  logic        sdata_out, sdata_oe, serial_strobe, frame_err;
  logic [6:0]  serial_addr, readback_addr;
  logic [31:0] serial_data, readback_data;
  logic [19:0] cyc = '0;

  always #5 master_clk = ~master_clk;
  always @(posedge master_clk) cyc <= cyc + 1'b1;

  // External readback table, selected combinationally from readback_addr.
  logic [31:0] rb_mem [128];
  assign readback_data = rb_mem[readback_addr];

  serial_settings_rx_marine_radar #(.SYNC_STAGES(SYNC)) dut (
    .master_clk(master_clk), .reset_n(reset_n), .sen_n(sen_n), .sclk(sclk),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .sdata_oe(sdata_oe),
    .serial_addr(serial_addr), .serial_data(serial_data),
    .serial_strobe(serial_strobe), .readback_addr(readback_addr),
    .readback_data(readback_data), .frame_err(frame_err)
  );

  // ---------------- scoreboard ----------------
  // Entry: {expected cycle[19:0], is_err, addr[6:0], data[31:0]}
  logic [59:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [6:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe or frame_err pulse must match the head of the queue.
  always @(negedge master_clk) begin
    logic [59:0] e;
    if (reset_n && (serial_strobe || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: strobe=%0b frame_err=%0b addr=0x%0h data=0x%0h expected none",
                 serial_strobe, frame_err, serial_addr, serial_data);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_err", {31'd0, frame_err}, {31'd0, e[39]});
        chk("event_kind_strobe", {31'd0, serial_strobe}, {31'd0, !e[39]});
        chk("event_cycle", {12'd0, cyc}, {12'd0, e[59:40]});
        if (!e[39]) begin
          chk("strobe_addr", {25'd0, serial_addr}, {25'd0, e[38:32]});
          chk("strobe_data", serial_data, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  // Sends the first nbits of {rw, addr, data} (zeros beyond 40 bits).
  // keep_low leaves sen_n asserted so the caller can abort the frame.
  task automatic send_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                            input int nbits, input bit keep_low);
    logic [39:0] fr;
    logic [31:0] rd_word;
    bit          is_err;
    fr      = {rw, addr, data};
    rd_word = '0;
    @(negedge master_clk);
    sen_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      sdata_in = (i < 40) ? fr[39-i] : 1'b0;
      wait_cyc(HALF);
      if (rw && i == 4) chk("oe_in_header", {31'd0, sdata_oe}, 32'd0);
      if (rw && i >= 8 && i < 40) begin
        if (i == 8) begin
          chk("oe_in_read_data", {31'd0, sdata_oe}, {31'd0, RB_EN});
          chk("readback_addr", {25'd0, readback_addr}, RB_EN ? {25'd0, addr} : 32'd0);
        end
        rd_word = {rd_word[30:0], sdata_out};
      end
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    if (keep_low) return;
    wait_cyc(HALF);
    sen_n = 1'b1;
    // Reference outcome of the frame, straight from the frame rules.
    is_err = !((nbits == 40) && (!rw || RB_EN));
    if (is_err) begin
      exp_q.push_back({cyc + 20'(SYNC + 1), 1'b1, 7'd0, 32'd0});
    end else if (!rw) begin
      exp_q.push_back({cyc + 20'(SYNC + 1), 1'b0, addr, data});
      last_addr = addr;
      last_data = data;
    end
    wait_cyc(SYNC + 3);
    chk("oe_after_frame", {31'd0, sdata_oe}, 32'd0);
    chk("hold_addr", {25'd0, serial_addr}, {25'd0, last_addr});
    chk("hold_data", serial_data, last_data);
    if (RB_EN && rw && nbits >= 40) chk("readback_word", rd_word, rb_mem[addr]);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr"}, {25'd0, serial_addr}, 32'd0);
    chk({tag, "_data"}, serial_data, 32'd0);
    chk({tag, "_strobe"}, {31'd0, serial_strobe}, 32'd0);
    chk({tag, "_rb_addr"}, {25'd0, readback_addr}, 32'd0);
    chk({tag, "_sdata_out"}, {31'd0, sdata_out}, 32'd0);
    chk({tag, "_sdata_oe"}, {31'd0, sdata_oe}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    logic rw;
    for (int k = 0; k < 128; k++) rb_mem[k] = $urandom;
    rb_mem[1] = 32'h12345678;

    wait_cyc(3);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    wait_cyc(HALF + 2);
    chk_outputs_zero("post_reset");

    // Directed frames.
    send_frame(1'b0, 7'h05, 32'hDEADBEEF, 40, 1'b0);
    send_frame(1'b0, 7'h2A, 32'hCAFEF00D, 39, 1'b0);
    send_frame(1'b1, 7'h01, 32'h0, 40, 1'b0);

    // Reset in the middle of a write frame, sen_n still low at release.
    send_frame(1'b0, 7'h44, 32'h55AA55AA, 20, 1'b1);
    reset_n = 1'b0;
    last_addr = '0;
    last_data = '0;
    wait_cyc(2);
    chk_outputs_zero("mid_reset");
    reset_n = 1'b1;
    wait_cyc(HALF + 2);
    sen_n = 1'b1;
    wait_cyc(HALF + 2);
    chk_outputs_zero("after_abort");
    send_frame(1'b0, 7'h10, 32'h00000003, 40, 1'b0);

    // Back-to-back writes at minimum gap.
    send_frame(1'b0, 7'h02, 32'h11111111, 40, 1'b0);
    send_frame(1'b0, 7'h03, 32'h22222222, 40, 1'b0);

    // Random frames: mostly well-formed, some short, some over-long.
    for (int k = 0; k < 40; k++) begin
      rw = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       nb = $urandom_range(1, 39);
        1:       nb = 41;
        default: nb = 40;
      endcase
      send_frame(rw, 7'($urandom_range(0, 127)), $urandom, nb, 1'b0);
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) wait_cyc(1);
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
